dec_lut_encoder20bits_clk: RTL and testbench
============================================

// Module: dec_lut_encoder20bits_clk
// PURPOSE
//  Forward (encode) side of the DEC_LUT 20-bit codec: maps index N to codeword W = (N*SCALE + BIAS) mod 2^W_BITS.
//  Iterative shift-add multiplier: one multiplier bit per cycle, start/busy/done handshake.
//  Generates the W stream that DEC_LUT_Decoder20bits_clk consumes. Its N/W widths match that decoder.
// PARAMETERS
//  N_BITS  21              index width (input N)
//  W_BITS  34              codeword width (output W); must equal N_BITS+S_BITS
//  S_BITS  13              SCALE width
//  SCALE   13'd5000        codeword multiplier
//  BIAS    34'd0           codeword offset, added after the product
// PORTS
//  clk    in   1        single clock, rising edge
//  rst    in   1        reset: one clock; reset is synchronous and active-high
//  start  in   1        request; sampled only in IDLE
//  N      in   N_BITS   index; captured on accepted start
//  busy   out  1        high from the cycle after an accepted start until done
//  done   out  1        one-cycle pulse; W valid from this cycle on
//  W      out  W_BITS   codeword; held until the next accepted start
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, busy=0, done=0, W=0, acc=0, cnt=0. Reset wins over every other input.
//  FSM IDLE -> MUL -> DONE -> IDLE.
//   IDLE: start=1 -> capture mcand=N and mult=SCALE zero-extended to W_BITS; acc=BIAS, cnt=0, busy=1 -> MUL.
//   MUL: if mcand[0], then acc += mult (mod 2^W_BITS). mcand >>= 1, mult <<= 1, cnt++.
//        After the step with cnt==N_BITS-1 -> DONE.
//   DONE: W<=acc, done=1 for exactly one cycle, busy=0 -> IDLE.
//  Latency: start sampled at edge t -> done high after edge t+N_BITS+1 (22 cycles at defaults).
//  start while busy: ignored. start in the DONE cycle: ignored. start in the cycle after done: accepted.
//  Back-to-back throughput: one codeword per N_BITS+2 cycles.
//  Arithmetic: all sums truncate to W_BITS. No overflow flag.
//   With the defaults, max N (2097151*5000=10485755000) fits without wrap.
//  N is sampled only at accept. Later changes on N have no effect on the operation in flight.
//  rst asserted mid-MUL: operation aborted, no done pulse, W cleared to 0.
// CONFIGURATION
//  ENC_EARLY_TERM_EN defined: MUL also goes to DONE as soon as the shifted mcand == 0.
//   N=0 -> done 2 cycles after start. Latency = 2 + index of the highest set bit of N.
//  Not defined: fixed N_BITS+1 latency for every N. The result W is identical in both builds.
// STRUCTURE
//  Package dec_lut_pkg: N_BITS/W_BITS/S_BITS localparams, enc_state_t {IDLE,MUL,DONE}, and the SCALE/BIAS defaults.
//   The decoder uses the same package so the codeword map is defined in one place.
//  One sub-module: dec_lut_shift_add_step. It is combinational and computes the next {acc, mcand, mult} for one MUL step.
//  The FSM, counter and output registers stay in the top module.
// TESTING
//  1 reset: rst=1 for 2 cycles with start=1 -> busy=0, done=0, W=0; no operation launched.
//  2 N=1048575 (defaults) -> done after exactly 22 cycles, W=5242875000.
//    Fed to DEC_LUT_Decoder20bits_clk, this W gives found=1, N=1048575.
//  3 N=0 -> W=0 (BIAS). Done at 22 cycles without ENC_EARLY_TERM_EN, at 2 cycles with it.
//  4 SCALE=8191, BIAS=2^34-1, N=2097151 -> W=17177763840 (wrap mod 2^34).
//  5 start pulsed every cycle during busy with N varying -> single done, W from the first captured N only.
//    start in the cycle after done -> accepted.
//  6 rst asserted at cycle 10 of MUL (N=12345) -> no done pulse, W=0.
//    Restart with N=12345 -> W=61725000.

Source files
------------

// File: rtl/dec_lut_pkg.sv
// Shared definitions for the DEC_LUT 20-bit codec (encoder and decoder).
// Holds the index/codeword widths, the default codeword map and the encoder state type.
package dec_lut_pkg;

  localparam int N_BITS   = 21;
  localparam int S_BITS   = 13;
  localparam int W_BITS   = N_BITS + S_BITS;
  localparam int CNT_BITS = $clog2(N_BITS);

  localparam logic [S_BITS-1:0] SCALE_DEFAULT = 13'd5000;
  localparam logic [W_BITS-1:0] BIAS_DEFAULT  = 34'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } enc_state_t;

endpackage

// File: rtl/dec_lut_shift_add_step.sv
// One combinational shift-add multiplier step: conditionally add the shifted
// multiplier into the accumulator, then advance multiplicand and multiplier by one bit.
import dec_lut_pkg::*;

module dec_lut_shift_add_step (
  input  logic [W_BITS-1:0] i_acc,
  input  logic [N_BITS-1:0] i_mcand,
  input  logic [W_BITS-1:0] i_mult,
  output logic [W_BITS-1:0] o_accNext,
  output logic [N_BITS-1:0] o_mcandNext,
  output logic [W_BITS-1:0] o_multNext
);

  // The sum truncates to W_BITS, which gives the mod 2^W_BITS codeword map.
  always_comb begin
    o_accNext   = i_mcand[0] ? (i_acc + i_mult) : i_acc;
    o_mcandNext = i_mcand >> 1;
    o_multNext  = i_mult << 1;
  end

endmodule

// File: rtl/dec_lut_encoder20bits_clk.sv
// DEC_LUT encoder: W = (N*SCALE + BIAS) mod 2^W_BITS via an iterative shift-add multiplier.
// Optional macro ENC_EARLY_TERM_EN ends the multiply once the remaining multiplicand is zero.
import dec_lut_pkg::*;

module dec_lut_encoder20bits_clk #(
  parameter logic [S_BITS-1:0] SCALE = SCALE_DEFAULT,
  parameter logic [W_BITS-1:0] BIAS  = BIAS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_BITS-1:0] N,
  output logic              busy,
  output logic              done,
  output logic [W_BITS-1:0] W
);

  enc_state_t r_state;
  enc_state_t w_stateNext;

  logic [W_BITS-1:0]   r_acc;
  logic [N_BITS-1:0]   r_mcand;
  logic [W_BITS-1:0]   r_mult;
  logic [CNT_BITS-1:0] r_cnt;
  logic [W_BITS-1:0]   r_W;
  logic                r_busy;
  logic                r_done;

  logic [W_BITS-1:0] w_accNext;
  logic [N_BITS-1:0] w_mcandNext;
  logic [W_BITS-1:0] w_multNext;
  logic              w_lastStep;
  logic              w_accept;
  logic              w_mulStep;
  logic              w_finish;

  dec_lut_shift_add_step u_step (
    .i_acc       (r_acc),
    .i_mcand     (r_mcand),
    .i_mult      (r_mult),
    .o_accNext   (w_accNext),
    .o_mcandNext (w_mcandNext),
    .o_multNext  (w_multNext)
  );

`ifdef ENC_EARLY_TERM_EN
  assign w_lastStep = (r_cnt == CNT_BITS'(N_BITS - 1)) || (w_mcandNext == '0);
`else
  assign w_lastStep = (r_cnt == CNT_BITS'(N_BITS - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (start) w_stateNext = MUL;
      MUL:     if (w_lastStep) w_stateNext = DONE;
      DONE:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_comb begin
    w_accept  = 1'b0;
    w_mulStep = 1'b0;
    w_finish  = 1'b0;
    case (r_state)
      IDLE:    w_accept  = start;
      MUL:     w_mulStep = 1'b1;
      DONE:    w_finish  = 1'b1;
      default: ;
    endcase
  end

  // Datapath and registered handshake; W only changes when an operation completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= '0;
      r_mcand <= '0;
      r_mult  <= '0;
      r_cnt   <= '0;
      r_W     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_mcand <= N;
        r_mult  <= {{(W_BITS - S_BITS){1'b0}}, SCALE};
        r_acc   <= BIAS;
        r_cnt   <= '0;
        r_busy  <= 1'b1;
      end
      if (w_mulStep) begin
        r_acc   <= w_accNext;
        r_mcand <= w_mcandNext;
        r_mult  <= w_multNext;
        r_cnt   <= r_cnt + CNT_BITS'(1);
      end
      if (w_finish) begin
        r_W    <= r_acc;
        r_done <= 1'b1;
        r_busy <= 1'b0;
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign W    = r_W;

endmodule

// File: tb/tb_dec_lut_encoder20bits_clk.sv
// Directed bench for dec_lut_encoder20bits_clk: a default-map instance plus one
// instance with SCALE=8191 and BIAS=2^34-1 for the wrap case. Honours ENC_EARLY_TERM_EN.
module tb_dec_lut_encoder20bits_clk;

  localparam int NB = 21;
  localparam int WB = 34;
  localparam int MAX_WAIT = 100;

  typedef struct {
    logic [NB-1:0] n;
    logic [WB-1:0] w;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          startA, startB;
  logic [NB-1:0] nA, nB;
  logic          busyA, busyB, doneA, doneB;
  logic [WB-1:0] wA, wB;

  int compared   = 0;
  int mismatched = 0;

  vec_t vecs[8];

  always #5 clk = ~clk;

  dec_lut_encoder20bits_clk dutA (
    .clk   (clk),
    .rst   (rst),
    .start (startA),
    .N     (nA),
    .busy  (busyA),
    .done  (doneA),
    .W     (wA)
  );

  dec_lut_encoder20bits_clk #(
    .SCALE (13'd8191),
    .BIAS  ({34{1'b1}})
  ) dutB (
    .clk   (clk),
    .rst   (rst),
    .start (startB),
    .N     (nB),
    .busy  (busyB),
    .done  (doneB),
    .W     (wB)
  );

  // Expected number of edges from the accept edge to the edge that raises done.
  function automatic int expLat(input logic [NB-1:0] n);
    int hi;
    hi = -1;
    for (int i = 0; i < NB; i++) if (n[i]) hi = i;
`ifdef ENC_EARLY_TERM_EN
    return (hi < 0) ? 2 : hi + 2;
`else
    return NB + 1;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Launch one operation on dutA; N is scrambled right after accept.
  task automatic applyStimulus(input logic [NB-1:0] n);
    @(negedge clk);
    startA = 1'b1;
    nA     = n;
    @(posedge clk);
    #1;
    startA = 1'b0;
    nA     = ~n;
  endtask

  task automatic waitDone(input bit useB, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!(useB ? doneB : doneA) && lat < MAX_WAIT);
  endtask

  initial begin
    int lat;
    int cyc;
    int doneCount;

    vecs[0] = '{n: 21'd1048575, w: 34'd5242875000};
    vecs[1] = '{n: 21'd0,       w: 34'd0};
    vecs[2] = '{n: 21'd1,       w: 34'd5000};
    vecs[3] = '{n: 21'd7,       w: 34'd35000};
    vecs[4] = '{n: 21'd1000000, w: 34'd5000000000};
    vecs[5] = '{n: 21'd2097151, w: 34'd10485755000};
    vecs[6] = '{n: 21'd1048576, w: 34'd5242880000};
    vecs[7] = '{n: 21'd12345,   w: 34'd61725000};

    rst = 1'b1; startA = 1'b1; nA = 21'd5; startB = 1'b0; nB = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", 64'(busyA), 64'd0);
    checkOutput("reset done", 64'(doneA), 64'd0);
    checkOutput("reset W", 64'(wA), 64'd0);
    @(negedge clk);
    rst = 1'b0; startA = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("no launch after reset", 64'(busyA), 64'd0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].n);
      checkOutput($sformatf("vec%0d busy", i), 64'(busyA), 64'd1);
      waitDone(1'b0, lat);
      checkOutput($sformatf("vec%0d latency", i), 64'(lat), 64'(expLat(vecs[i].n)));
      checkOutput($sformatf("vec%0d W", i), 64'(wA), 64'(vecs[i].w));
      checkOutput($sformatf("vec%0d busy at done", i), 64'(busyA), 64'd0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d done pulse", i), 64'(doneA), 64'd0);
      checkOutput($sformatf("vec%0d W held", i), 64'(wA), 64'(vecs[i].w));
    end

    // Wrap case: full-scale N with all-ones bias.
    @(negedge clk);
    startB = 1'b1; nB = 21'd2097151;
    @(posedge clk);
    #1;
    startB = 1'b0;
    waitDone(1'b1, lat);
    checkOutput("wrap latency", 64'(lat), 64'(expLat(21'd2097151)));
    checkOutput("wrap W", 64'(wB), 64'd17177763840);

    // start held high with varying N throughout the operation and its DONE cycle.
    applyStimulus(21'd100);
    cyc = 0;
    do begin
      @(negedge clk);
      startA = 1'b1;
      nA     = NB'($urandom);
      @(posedge clk);
      #1;
      cyc++;
    end while (!doneA && cyc < MAX_WAIT);
    checkOutput("busy-start latency", 64'(cyc), 64'(expLat(21'd100)));
    checkOutput("busy-start W", 64'(wA), 64'd500000);
    @(negedge clk);
    startA = 1'b1; nA = 21'd3;
    @(posedge clk);
    #1;
    startA = 1'b0; nA = 21'd9;
    checkOutput("accept after done busy", 64'(busyA), 64'd1);
    checkOutput("accept after done pulse", 64'(doneA), 64'd0);
    waitDone(1'b0, lat);
    checkOutput("accept after done latency", 64'(lat), 64'(expLat(21'd3)));
    checkOutput("accept after done W", 64'(wA), 64'd15000);

    // Reset in the middle of a multiply aborts it.
    applyStimulus(21'd12345);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    doneCount = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (doneA) doneCount++;
    end
    checkOutput("abort done count", 64'(doneCount), 64'd0);
    checkOutput("abort W", 64'(wA), 64'd0);
    checkOutput("abort busy", 64'(busyA), 64'd0);
    applyStimulus(21'd12345);
    waitDone(1'b0, lat);
    checkOutput("restart latency", 64'(lat), 64'(expLat(21'd12345)));
    checkOutput("restart W", 64'(wA), 64'd61725000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
